spi_cfg_regbank: RTL

//  Parametrised SPI-slave configuration register bank with read-back and per-operation start

---
 rtl/spi_cfg_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/spi_cfg_regbank.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_pkg
// Description : Shared types and helpers for the SPI configuration register
//               bank: frame FSM state encoding and frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

  // Frame receive FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    DATA   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Full frame length: rw bit + address field + data field
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : W-bit two-flop synchroniser followed by a one-flop edge
//               detector producing single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_LVL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  // Resynchronise into clk domain and keep one cycle of history for edges;
  // reset to the idle level so no spurious edge follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_LVL;
      sync_q <= RST_LVL;
      prev_q <= RST_LVL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_cfg_regbank.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_regbank
// Description : SPI-slave configuration register bank. Serial frames
//               {rw, addr, data} write or read live registers; op-start
//               rising edges pulse op_go and snapshot live into shadow.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cfg_regbank
  import spi_cfg_pkg::*;
#(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 8,
  parameter int                NUM_OPS  = 2,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_clk_i,
  input  logic                       spi_en_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  input  logic [NUM_OPS-1:0]         op_st_i,
  input  logic                       err_clr_i,
  output logic [NUM_OPS-1:0]         op_go_o,
  output logic                       wr_strobe_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [NUM_REGS*DATA_W-1:0] cfg_live_o,
  output logic [NUM_REGS*DATA_W-1:0] cfg_shadow_o,
  output logic                       err_frame_o,
  output logic                       err_addr_o
);

  localparam int               FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int               HDR_W   = 1 + ADDR_W;
  localparam int               CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [ADDR_W:0]  NREG_L  = (ADDR_W + 1)'(NUM_REGS);

  // ---------------------------------------------------------------- sync
  logic [2:0]         w_pin_q, w_pin_rise, w_pin_fall;
  logic [NUM_OPS-1:0] w_op_q, w_op_rise, w_op_fall;

  // Pins packed as {spi_clk, spi_en, spi_mosi}; clock and enable idle high
  spi_sync_edge #(.W(3), .RST_LVL(3'b110)) u_pin_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    ({spi_clk_i, spi_en_i, spi_mosi_i}),
    .q_o    (w_pin_q),
    .rise_o (w_pin_rise),
    .fall_o (w_pin_fall)
  );

  spi_sync_edge #(.W(NUM_OPS), .RST_LVL('0)) u_op_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (op_st_i),
    .q_o    (w_op_q),
    .rise_o (w_op_rise),
    .fall_o (w_op_fall)
  );

  logic w_sck_rise, w_sck_fall, w_en_rise, w_en_fall, w_mosi;
  assign w_sck_rise = w_pin_rise[2];
  assign w_sck_fall = w_pin_fall[2];
  assign w_en_rise  = w_pin_rise[1];
  assign w_en_fall  = w_pin_fall[1];
  assign w_mosi     = w_pin_q[0];

  // ---------------------------------------------------------------- state
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [FRAME_W-2:0]  rx_sh_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                miso_q;
  logic                wr_strobe_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                err_frame_q;
  logic                err_addr_q;
  logic [DATA_W-1:0]   live_q   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [NUM_OPS-1:0]  op_go_q;

  // Frame contents including the bit arriving this cycle
  logic [FRAME_W-1:0]  w_rx_next;
  logic [ADDR_W-1:0]   w_hdr_addr;
  logic                w_hdr_bad;
  logic                w_addr_bad;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_rx_next  = {rx_sh_q, w_mosi};
  assign w_hdr_addr = w_rx_next[ADDR_W-1:0];
  assign w_hdr_bad  = ({1'b0, w_hdr_addr} >= NREG_L);
  assign w_addr_bad = ({1'b0, addr_q} >= NREG_L);

  // Read-back mux; out-of-range addresses return zero
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_hdr_addr == ADDR_W'(i)) w_rd_data = live_q[i];
    end
  end

  // Frame FSM: header/data shifting, read-out, register commit and errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_frame_q <= 1'b0;
      err_addr_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) live_q[i] <= RST_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      // Clear only what is already set; a later set below overrides
      err_frame_q <= err_frame_q & ~err_clr_i;
      err_addr_q  <= err_addr_q & ~err_clr_i;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (w_en_fall) begin
            state_q <= HDR;
            cnt_q   <= '0;
          end
        end
        HDR: begin
          if (w_en_rise) begin
            state_q     <= IDLE;
            err_frame_q <= 1'b1;
          end else if (w_sck_rise) begin
            rx_sh_q <= w_rx_next[FRAME_W-2:0];
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HDR_W - 1)) begin
              state_q <= DATA;
              rw_q    <= w_rx_next[ADDR_W];
              addr_q  <= w_hdr_addr;
              tx_sh_q <= w_rd_data;
              if (w_rx_next[ADDR_W] && w_hdr_bad) err_addr_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_en_rise) begin
            state_q     <= IDLE;
            miso_q      <= 1'b0;
            err_frame_q <= 1'b1;
          end else begin
            if (w_sck_fall) begin
              miso_q  <= tx_sh_q[DATA_W-1];
              tx_sh_q <= tx_sh_q << 1;
            end
            if (w_sck_rise) begin
              rx_sh_q <= w_rx_next[FRAME_W-2:0];
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                state_q <= COMMIT;
                miso_q  <= 1'b0;
                if (!rw_q) begin
                  if (w_addr_bad) begin
                    err_addr_q <= 1'b1;
                  end else begin
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= addr_q;
                    for (int i = 0; i < NUM_REGS; i++) begin
                      if (addr_q == ADDR_W'(i)) live_q[i] <= w_rx_next[DATA_W-1:0];
                    end
                  end
                end
              end
            end
          end
        end
        COMMIT: begin
          // Chip select may already be released while the commit happens
          state_q <= w_en_rise ? IDLE : DONE;
        end
        DONE: begin
          if (w_en_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Op-start pulses; shadow captures live as it stood before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_go_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= RST_VAL;
    end else begin
      op_go_q <= w_op_rise;
      if (|w_op_rise) shadow_q <= live_q;
    end
  end

  // ---------------------------------------------------------------- outputs
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
      assign cfg_live_o[gi*DATA_W +: DATA_W]   = live_q[gi];
      assign cfg_shadow_o[gi*DATA_W +: DATA_W] = shadow_q[gi];
    end
  endgenerate

  assign spi_miso_o  = miso_q;
  assign op_go_o     = op_go_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign err_frame_o = err_frame_q;
  assign err_addr_o  = err_addr_q;

  // Synchroniser outputs that this block has no use for
  logic w_unused;
  assign w_unused = &{1'b0, w_pin_q[2:1], w_pin_rise[0], w_pin_fall[0],
                      w_op_q, w_op_fall, w_rx_next[FRAME_W-1]};

endmodule
`default_nettype wire
